multicycle_core_p: RTL
======================

Name: multicycle_core_p

Overview:
- Parametrised successor of the team's 16-bit-instruction multi-cycle core.
- Fetches, decodes and executes one instruction at a time from a single shared RAM port.
- Adds the following over the previous generation:
  - configurable data width, address width and reset PC;
  - full SF/ZF/OF flags, with working JUMPL/JUMPG;
  - JUMPLI/RET link register;
  - a memory ready handshake (wait states);
  - a halt on illegal opcodes.
- Contains its own register file. Sits between the boot/RAM arbiter and the instruction/data RAM.

Parameters:
- DATA_W, 24, register/ALU width (16..32).
- ADDR_W, 15, RAM word-address and PC width.
- NUM_REGS, 32, register count (index field is 5 bits; indices >= NUM_REGS read 0, writes ignored).
- RESET_PC, 9216, PC value after reset.

Ports:
- clk, input, 1, core clock, rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- mem_rdata, input, 16, RAM read data, valid when mem_ready=1.
- mem_ready, input, 1, RAM completes the current request this cycle.
- mem_req, output, 1, access request.
- mem_we, output, 1, write strobe (only with mem_req).
- mem_addr, output, ADDR_W, word address.
- mem_wdata, output, 16, store data.
- pc, output, ADDR_W, current program counter.
- flags, output, 3, {SF,ZF,OF}.
- halted, output, 1, core stopped on an illegal opcode.

Behaviour:
- **Reset interface statement:** one clock (clk); reset is asynchronous and active-low (rst_n).
- **Reset values:**
  - pc=RESET_PC; flags=0; link=0; all registers=0; state=FETCH; halted=0.
  - mem_req/mem_we/mem_addr/mem_wdata are 0 while rst_n=0.
  - Reset mid-access abandons the access; no register or flag update.
- **Instruction fields:** opcode=[15:11], A=[4:0] (destination/first source), B=[9:5], immS=[10:5] zero-extended, immL=[10:0] zero-extended/truncated to ADDR_W.
- **States:**
  - FETCH: mem_req=1, mem_addr=pc, mem_we=0. Hold until mem_ready; then latch mem_rdata as the instruction and go to DECODE.
  - DECODE: read rA and rB into holding registers.
    - LOAD(01101) or STORE(01111) -> MEM.
    - Opcodes 10001..11111 -> HALT.
    - Otherwise -> EXECUTE.
  - EXECUTE: one cycle. Register write, flag update and PC update at its closing edge -> FETCH.
  - MEM: hold until mem_ready, then pc<=pc+1 -> FETCH.
    - LOAD: mem_addr=rB[ADDR_W-1:0]; rA<=zero-extended mem_rdata.
    - STORE: mem_we=1, mem_addr=rA[ADDR_W-1:0], mem_wdata=rB[15:0].
  - HALT: halted=1, mem_req=0; the core stays here until reset.
- **Outputs:** mem_* are combinational from state and holding registers and are held stable while waiting.
- **Operations (mod 2^DATA_W, default pc<=pc+1, pc wraps mod 2^ADDR_W):**
  - ADD rA<=rA+rB; SUB rA<=rA-rB.
  - ADDI rA<=rA+immS.
  - SHLLI / SHRLI: logical shift of rA by immS; shift >= DATA_W gives 0.
  - MOV rA<=rB; LOADI rA<=immS.
  - CMP: d=rA-rB. ZF=(d==0), SF=d[MSB], OF=(rA[MSB]!=rB[MSB])&&(d[MSB]!=rA[MSB]). No register write.
  - JUMP pc<=immL.
  - JUMPLI: link<=pc+1, pc<=immL.
  - RET pc<=link.
  - JUMPL taken if SF!=OF; JUMPG if SF==OF && !ZF; JUMPE if ZF; JUMPNE if !ZF. Not taken -> pc+1.
- **Flags:** change only on CMP.
- **Latency:** with mem_ready tied 1, every instruction takes 3 cycles (FETCH, DECODE, EXECUTE/MEM). Each ready=0 cycle adds one.
- **Register file:** a write and a read of the same register in one cycle return the old value (no bypass needed, since the stages are serial).

Test Plan:
- Reset with mem_ready=1: release rst_n -> first mem_req with mem_addr=9216; pc=9216; flags=000; halted=0.
- LOADI r1,5; LOADI r2,7; ADD r1,r2 -> r1=12; pc=9219 after 9 cycles.
- CMP r1=3 vs r2=5 -> SF=1, ZF=0, OF=0; JUMPL 100 -> pc=100. CMP r1=5 vs r2=5 -> ZF=1; JUMPG not taken -> pc+1.
- JUMPLI 200 at pc=9220 -> pc=200, link=9221. RET -> pc=9221.
- STORE with mem_ready low 3 cycles -> mem_req/mem_we/mem_addr/mem_wdata held 4 cycles; pc increments only after ready. LOAD 0xFFFF (DATA_W=24) -> 0x00FFFF.
- Opcode 11111 -> halted=1 after DECODE, mem_req=0 forever. Assert rst_n=0 mid-FETCH wait -> immediate return to reset values.

Source files
------------

// File: rtl/multicycle_core_p_if.sv
// Memory port of the multi-cycle core: request/write strobe/address/store
// data towards the RAM, read data and a ready handshake back from it.
interface multicycle_core_p_if #(
    parameter int ADDR_W = 15
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic [15:0]       mem_rdata;
    logic              mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/multicycle_core_p.sv
// Parametrised 16-bit-instruction multi-cycle core.
// FETCH -> DECODE -> EXECUTE|MEM -> FETCH, one shared RAM port with a ready
// handshake, SF/ZF/OF flags, link register, halt on illegal opcodes.
// Opcode map (bits [15:11]):
//   00000 ADD    00001 SUB    00010 ADDI   00011 SHLLI  00100 SHRLI
//   00101 MOV    00110 LOADI  00111 CMP    01000 JUMP   01001 JUMPLI
//   01010 RET    01011 JUMPL  01100 JUMPG  01101 LOAD   01110 JUMPE
//   01111 STORE  10000 JUMPNE 10001..11111 illegal (halt)
module multicycle_core_p #(
    parameter int DATA_W   = 24,
    parameter int ADDR_W   = 15,
    parameter int NUM_REGS = 32,
    parameter int RESET_PC = 9216
) (
    input  logic                clk,
    input  logic                rst_n,
    multicycle_core_p_if.master bus,
    output logic [ADDR_W-1:0]   pc,
    output logic [2:0]          flags,
    output logic                halted
);
    localparam int MSB = DATA_W - 1;
    localparam logic [ADDR_W-1:0] RESET_PC_W = ADDR_W'(RESET_PC);

    localparam logic [4:0] OP_ADD    = 5'b00000;
    localparam logic [4:0] OP_SUB    = 5'b00001;
    localparam logic [4:0] OP_ADDI   = 5'b00010;
    localparam logic [4:0] OP_SHLLI  = 5'b00011;
    localparam logic [4:0] OP_SHRLI  = 5'b00100;
    localparam logic [4:0] OP_MOV    = 5'b00101;
    localparam logic [4:0] OP_LOADI  = 5'b00110;
    localparam logic [4:0] OP_CMP    = 5'b00111;
    localparam logic [4:0] OP_JUMP   = 5'b01000;
    localparam logic [4:0] OP_JUMPLI = 5'b01001;
    localparam logic [4:0] OP_RET    = 5'b01010;
    localparam logic [4:0] OP_JUMPL  = 5'b01011;
    localparam logic [4:0] OP_JUMPG  = 5'b01100;
    localparam logic [4:0] OP_LOAD   = 5'b01101;
    localparam logic [4:0] OP_JUMPE  = 5'b01110;
    localparam logic [4:0] OP_STORE  = 5'b01111;
    localparam logic [4:0] OP_JUMPNE = 5'b10000;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEM,
        S_HALT
    } state_t;

    state_t              state_reg, state_next;
    logic [15:0]         ir_reg;
    logic [DATA_W-1:0]   ra_reg, rb_reg;
    logic [ADDR_W-1:0]   pc_reg, link_reg;
    logic [2:0]          flags_reg;          // {SF, ZF, OF}

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [DATA_W-1:0]   rd_a, rd_b;
    logic                rf_we;
    logic [4:0]          rf_waddr;
    logic [DATA_W-1:0]   rf_wdata;

    // Instruction fields
    logic [4:0]          opcode, idx_a, idx_b;
    logic [DATA_W-1:0]   imm_s;
    logic [ADDR_W-1:0]   imm_l, pc_plus1;
    logic                is_load, is_store;

    assign opcode   = ir_reg[15:11];
    assign idx_a    = ir_reg[4:0];
    assign idx_b    = ir_reg[9:5];
    assign imm_s    = DATA_W'(ir_reg[10:5]);
    assign imm_l    = ADDR_W'(ir_reg[10:0]);
    assign pc_plus1 = pc_reg + ADDR_W'(1);
    assign is_load  = (opcode == OP_LOAD);
    assign is_store = (opcode == OP_STORE);

    // Execute-stage results
    logic [DATA_W-1:0]   alu_diff, exec_val;
    logic [2:0]          cmp_flags;
    logic                exec_wr, exec_link, exec_cmp;
    logic [ADDR_W-1:0]   exec_pc;
    logic                sf, zf, of;

    assign sf = flags_reg[2];
    assign zf = flags_reg[1];
    assign of = flags_reg[0];

    // Register file read ports; indices beyond NUM_REGS read as zero
    always_comb begin
        rd_a = '0;
        rd_b = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (idx_a == 5'(i)) rd_a = regs[i];
            if (idx_b == 5'(i)) rd_b = regs[i];
        end
    end

    // One flop bank per register; writes to absent indices match nothing
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_rf
            // Register gi write
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    regs[gi] <= '0;
                else if (rf_we && rf_waddr == 5'(gi))
                    regs[gi] <= rf_wdata;
            end
        end
    endgenerate

    // ALU, compare flags and next-PC selection for the EXECUTE cycle
    always_comb begin
        alu_diff  = ra_reg - rb_reg;
        cmp_flags = {alu_diff[MSB],
                     (alu_diff == '0),
                     (ra_reg[MSB] != rb_reg[MSB]) && (alu_diff[MSB] != ra_reg[MSB])};
        exec_val  = '0;
        exec_wr   = 1'b0;
        exec_link = 1'b0;
        exec_cmp  = 1'b0;
        exec_pc   = pc_plus1;
        case (opcode)
            OP_ADD:    begin exec_wr = 1'b1; exec_val = ra_reg + rb_reg; end
            OP_SUB:    begin exec_wr = 1'b1; exec_val = alu_diff; end
            OP_ADDI:   begin exec_wr = 1'b1; exec_val = ra_reg + imm_s; end
            OP_SHLLI:  begin
                exec_wr  = 1'b1;
                exec_val = (int'(ir_reg[10:5]) >= DATA_W) ? '0 : (ra_reg << ir_reg[10:5]);
            end
            OP_SHRLI:  begin
                exec_wr  = 1'b1;
                exec_val = (int'(ir_reg[10:5]) >= DATA_W) ? '0 : (ra_reg >> ir_reg[10:5]);
            end
            OP_MOV:    begin exec_wr = 1'b1; exec_val = rb_reg; end
            OP_LOADI:  begin exec_wr = 1'b1; exec_val = imm_s; end
            OP_CMP:    exec_cmp = 1'b1;
            OP_JUMP:   exec_pc = imm_l;
            OP_JUMPLI: begin exec_link = 1'b1; exec_pc = imm_l; end
            OP_RET:    exec_pc = link_reg;
            OP_JUMPL:  if (sf != of)         exec_pc = imm_l;
            OP_JUMPG:  if (sf == of && !zf)  exec_pc = imm_l;
            OP_JUMPE:  if (zf)               exec_pc = imm_l;
            OP_JUMPNE: if (!zf)              exec_pc = imm_l;
            default:   ;
        endcase
    end

    // Register file write: ALU result in EXECUTE, load data when MEM completes
    always_comb begin
        rf_waddr = idx_a;
        rf_we    = 1'b0;
        rf_wdata = exec_val;
        if (state_reg == S_EXECUTE) begin
            rf_we = exec_wr;
        end else if (state_reg == S_MEM && is_load && bus.mem_ready) begin
            rf_we    = 1'b1;
            rf_wdata = DATA_W'(bus.mem_rdata);
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= S_FETCH;
        else        state_reg <= state_next;
    end

    // Next state and memory-port drive; port values depend only on state and
    // latched registers so they stay stable across wait states
    logic              req_c, we_c;
    logic [ADDR_W-1:0] addr_c;
    logic [15:0]       wdata_c;

    always_comb begin
        state_next = state_reg;
        req_c      = 1'b0;
        we_c       = 1'b0;
        addr_c     = '0;
        wdata_c    = '0;
        case (state_reg)
            S_FETCH: begin
                req_c  = 1'b1;
                addr_c = pc_reg;
                if (bus.mem_ready) state_next = S_DECODE;
            end
            S_DECODE: begin
                if (is_load || is_store)  state_next = S_MEM;
                else if (opcode > OP_JUMPNE) state_next = S_HALT;
                else                      state_next = S_EXECUTE;
            end
            S_EXECUTE: state_next = S_FETCH;
            S_MEM: begin
                req_c   = 1'b1;
                we_c    = is_store;
                addr_c  = is_store ? ra_reg[ADDR_W-1:0] : rb_reg[ADDR_W-1:0];
                wdata_c = is_store ? rb_reg[15:0] : 16'h0000;
                if (bus.mem_ready) state_next = S_FETCH;
            end
            S_HALT:  state_next = S_HALT;
            default: state_next = S_FETCH;
        endcase
    end

    // The port is forced quiet for as long as reset is asserted
    assign bus.mem_req   = rst_n & req_c;
    assign bus.mem_we    = rst_n & we_c;
    assign bus.mem_addr  = rst_n ? addr_c  : '0;
    assign bus.mem_wdata = rst_n ? wdata_c : '0;

    // Datapath registers: instruction latch, operand holding, PC, link, flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_reg    <= '0;
            ra_reg    <= '0;
            rb_reg    <= '0;
            pc_reg    <= RESET_PC_W;
            link_reg  <= '0;
            flags_reg <= '0;
        end else begin
            case (state_reg)
                S_FETCH:  if (bus.mem_ready) ir_reg <= bus.mem_rdata;
                S_DECODE: begin
                    ra_reg <= rd_a;
                    rb_reg <= rd_b;
                end
                S_EXECUTE: begin
                    pc_reg <= exec_pc;
                    if (exec_link) link_reg  <= pc_plus1;
                    if (exec_cmp)  flags_reg <= cmp_flags;
                end
                S_MEM:    if (bus.mem_ready) pc_reg <= pc_plus1;
                default:  ;
            endcase
        end
    end

    assign pc     = pc_reg;
    assign flags  = flags_reg;
    assign halted = (state_reg == S_HALT);
endmodule
